// File: rtl/rx_stats_pkg.sv
// Shared constants for the receive statistics block: counter map and default widths.
package rx_stats_pkg;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_OCT_W   = 48;
   localparam int DEF_LEN_W   = 16;
   localparam int STAT_DATA_W = 64;
   localparam int NUM_CNT     = 8;

   typedef enum logic [2:0] {
      GOOD_FRAMES = 3'd0,
      BAD_FRAMES  = 3'd1,
      GOOD_OCTETS = 3'd2,
      CRC_ERR     = 3'd3,
      LEN_ERR     = 3'd4,
      DA_MISMATCH = 3'd5,
      TAGGED_GOOD = 3'd6,
      SMALL_GOOD  = 3'd7
   } stat_addr_e;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 0 + increment.
module rx_sat_counter #(
   parameter int W  = 32,
   parameter int IW = 1
) (
   input  logic          rxclk,
   input  logic          reset,
   input  logic          inc_en,
   input  logic [IW-1:0] inc_val,
   input  logic          clr,
   output logic [W-1:0]  count
);

   // One spare bit above the wider operand catches any overflow of the add
   localparam int SW = ((W > IW) ? W : IW) + 1;

   logic [W-1:0]  r_count;
   logic [W-1:0]  w_base;
   logic [SW-1:0] w_sum;
   logic          w_ovf;
   logic [W-1:0]  w_next;

   assign w_base = clr ? '0 : r_count;
   assign w_sum  = SW'(w_base) + (inc_en ? SW'(inc_val) : '0);
   assign w_ovf  = |w_sum[SW-1:W];
   assign w_next = w_ovf ? '1 : w_sum[W-1:0];

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/rx_stats_counters.sv
// Receive statistics: live saturating counters, cause latches, snapshot shadows and read port.
module rx_stats_counters
   import rx_stats_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int OCT_W = DEF_OCT_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic                   rxclk,
   input  logic                   reset,
   input  logic                   good_frame_get,
   input  logic                   bad_frame_get,
   input  logic                   crc_check_invalid,
   input  logic                   length_error,
   input  logic                   local_invalid,
   input  logic                   tagged_frame,
   input  logic                   small_frame,
   input  logic [LEN_W-1:0]       frame_len,
   input  logic                   stat_snap,
   input  logic                   clr_on_snap,
   input  logic                   stat_rd,
   input  logic [2:0]             stat_addr,
   output logic [STAT_DATA_W-1:0] stat_data,
   output logic                   stat_valid
);

   logic                   r_len_f;
   logic                   r_da_f;
   logic [STAT_DATA_W-1:0] r_shadow [NUM_CNT];
   logic [STAT_DATA_W-1:0] r_stat_data;
   logic                   r_stat_valid;

   logic [STAT_DATA_W-1:0] w_live [NUM_CNT];
   logic [NUM_CNT-1:0]     w_inc;
   logic                   w_clr;
   logic                   w_frame_end;

   assign w_frame_end = good_frame_get | bad_frame_get;
   assign w_clr       = stat_snap & clr_on_snap;

   // Bit order follows the counter address map
   assign w_inc = {good_frame_get & small_frame,
                   good_frame_get & tagged_frame,
                   bad_frame_get  & (r_da_f  | local_invalid),
                   bad_frame_get  & (r_len_f | length_error),
                   crc_check_invalid,
                   good_frame_get,
                   bad_frame_get,
                   good_frame_get};

   // Cause latches: frame completion clears them and wins over a same-cycle set
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         r_len_f <= 1'b0;
         r_da_f  <= 1'b0;
      end else if (w_frame_end) begin
         r_len_f <= 1'b0;
         r_da_f  <= 1'b0;
      end else begin
         if (length_error)  r_len_f <= 1'b1;
         if (local_invalid) r_da_f  <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         if (gi == int'(GOOD_OCTETS)) begin : g_oct
            logic [OCT_W-1:0] w_count;
            rx_sat_counter #(.W(OCT_W), .IW(LEN_W)) u_cnt (
               .rxclk   (rxclk),
               .reset   (reset),
               .inc_en  (w_inc[gi]),
               .inc_val (frame_len),
               .clr     (w_clr),
               .count   (w_count)
            );
            assign w_live[gi] = STAT_DATA_W'(w_count);
         end else begin : g_evt
            logic [CNT_W-1:0] w_count;
            rx_sat_counter #(.W(CNT_W), .IW(1)) u_cnt (
               .rxclk   (rxclk),
               .reset   (reset),
               .inc_en  (w_inc[gi]),
               .inc_val (1'b1),
               .clr     (w_clr),
               .count   (w_count)
            );
            assign w_live[gi] = STAT_DATA_W'(w_count);
         end
      end
   endgenerate

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) r_shadow[i] <= '0;
      end else if (stat_snap) begin
         for (int i = 0; i < NUM_CNT; i++) r_shadow[i] <= w_live[i];
      end
   end

   // Read samples the shadow on the strobe edge, so a concurrent snap is not yet visible
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         r_stat_data  <= '0;
         r_stat_valid <= 1'b0;
      end else begin
         r_stat_valid <= stat_rd;
         if (stat_rd) r_stat_data <= r_shadow[stat_addr];
      end
   end

   assign stat_data  = r_stat_data;
   assign stat_valid = r_stat_valid;

endmodule

// File: tb/tb_rx_stats_counters.sv
// Scoreboard bench for rx_stats_counters: a full-width instance plus a 16-bit octet instance for saturation.
module tb_rx_stats_counters;

   localparam logic [63:0] CMAX = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] OMAX = 64'h0000_FFFF_FFFF_FFFF;
   localparam logic [63:0] SMAX = 64'h0000_0000_0000_FFFF;

   logic        rxclk = 1'b0;
   logic        reset = 1'b0;
   logic        good_frame_get = 1'b0;
   logic        bad_frame_get = 1'b0;
   logic        crc_check_invalid = 1'b0;
   logic        length_error = 1'b0;
   logic        local_invalid = 1'b0;
   logic        tagged_frame = 1'b0;
   logic        small_frame = 1'b0;
   logic [15:0] frame_len = '0;
   logic        stat_snap = 1'b0;
   logic        clr_on_snap = 1'b0;
   logic        stat_rd = 1'b0;
   logic [2:0]  stat_addr = '0;
   logic [63:0] stat_data, stat_data_s;
   logic        stat_valid, stat_valid_s;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [63:0] exp_big;
      logic [63:0] exp_small;
      logic [2:0]  addr;
   } rd_t;
   rd_t sb[$];

   logic [63:0] m_live [8];
   logic [63:0] m_shadow [8];
   logic [63:0] m_oct_s, m_sh_oct_s;
   logic        m_len_f, m_da_f;
   logic        exp_valid = 1'b0;

   rx_stats_counters dut (
      .rxclk(rxclk), .reset(reset), .good_frame_get(good_frame_get), .bad_frame_get(bad_frame_get),
      .crc_check_invalid(crc_check_invalid), .length_error(length_error), .local_invalid(local_invalid),
      .tagged_frame(tagged_frame), .small_frame(small_frame), .frame_len(frame_len),
      .stat_snap(stat_snap), .clr_on_snap(clr_on_snap), .stat_rd(stat_rd), .stat_addr(stat_addr),
      .stat_data(stat_data), .stat_valid(stat_valid)
   );

   rx_stats_counters #(.OCT_W(16)) dut_s (
      .rxclk(rxclk), .reset(reset), .good_frame_get(good_frame_get), .bad_frame_get(bad_frame_get),
      .crc_check_invalid(crc_check_invalid), .length_error(length_error), .local_invalid(local_invalid),
      .tagged_frame(tagged_frame), .small_frame(small_frame), .frame_len(frame_len),
      .stat_snap(stat_snap), .clr_on_snap(clr_on_snap), .stat_rd(stat_rd), .stat_addr(stat_addr),
      .stat_data(stat_data_s), .stat_valid(stat_valid_s)
   );

   always #5 rxclk = ~rxclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sat(input logic [63:0] v, input logic [63:0] max);
      return (v > max) ? max : v;
   endfunction

   task automatic model_zero();
      for (int i = 0; i < 8; i++) begin
         m_live[i] = '0;
         m_shadow[i] = '0;
      end
      m_oct_s = '0;
      m_sh_oct_s = '0;
      m_len_f = 1'b0;
      m_da_f = 1'b0;
   endtask

   // Advance one clock, updating the reference model from the inputs sampled on that edge
   task automatic tick();
      logic [63:0] inc [8];
      logic        clr;
      logic        rd_q;
      if (reset) begin
         model_zero();
      end else begin
         if (stat_rd)
            sb.push_back('{m_shadow[stat_addr],
                           (stat_addr == 3'd2) ? m_sh_oct_s : m_shadow[stat_addr], stat_addr});
         if (stat_snap) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = m_live[i];
            m_sh_oct_s = m_oct_s;
         end
         inc[0] = 64'(good_frame_get);
         inc[1] = 64'(bad_frame_get);
         inc[2] = good_frame_get ? 64'(frame_len) : 64'd0;
         inc[3] = 64'(crc_check_invalid);
         inc[4] = 64'(bad_frame_get & (m_len_f | length_error));
         inc[5] = 64'(bad_frame_get & (m_da_f | local_invalid));
         inc[6] = 64'(good_frame_get & tagged_frame);
         inc[7] = 64'(good_frame_get & small_frame);
         clr = stat_snap & clr_on_snap;
         for (int i = 0; i < 8; i++)
            m_live[i] = sat((clr ? 64'd0 : m_live[i]) + inc[i], (i == 2) ? OMAX : CMAX);
         m_oct_s = sat((clr ? 64'd0 : m_oct_s) + inc[2], SMAX);
         if (good_frame_get | bad_frame_get) begin
            m_len_f = 1'b0;
            m_da_f = 1'b0;
         end else begin
            if (length_error) m_len_f = 1'b1;
            if (local_invalid) m_da_f = 1'b1;
         end
      end
      rd_q = stat_rd & ~reset;
      @(posedge rxclk);
      #1;
      exp_valid = rd_q;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic good(input logic [15:0] len, input logic tag, input logic sml);
      good_frame_get = 1'b1; frame_len = len; tagged_frame = tag; small_frame = sml;
      tick();
      good_frame_get = 1'b0; tagged_frame = 1'b0; small_frame = 1'b0;
   endtask

   task automatic bad();
      bad_frame_get = 1'b1;
      tick();
      bad_frame_get = 1'b0;
   endtask

   task automatic snap(input logic clr);
      stat_snap = 1'b1; clr_on_snap = clr;
      tick();
      stat_snap = 1'b0; clr_on_snap = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      stat_rd = 1'b1; stat_addr = a;
      tick();
      stat_rd = 1'b0;
   endtask

   // Output side of the scoreboard: one line per completed read
   always @(negedge rxclk) begin
      rd_t item;
      check("valid", 64'(stat_valid), 64'(exp_valid));
      check("valid_s", 64'(stat_valid_s), 64'(exp_valid));
      if (stat_valid) begin
         check("sb_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            item = sb.pop_front();
            check($sformatf("rd%0d", item.addr), stat_data, item.exp_big);
            check($sformatf("rd%0d_s", item.addr), stat_data_s, item.exp_small);
            $display("read addr=%0d data=0x%0h data_s=0x%0h", item.addr, stat_data, stat_data_s);
         end
      end
   end

   initial begin
      model_zero();
      #1 reset = 1'b1;
      idle(3);
      check("rst_data", stat_data, 64'd0);
      check("rst_data_s", stat_data_s, 64'd0);
      reset = 1'b0;
      idle(2);
      for (int a = 0; a < 8; a++) rd(3'(a));

      good(16'd64, 1'b0, 1'b0);
      good(16'd1518, 1'b1, 1'b0);
      good(16'd9000, 1'b0, 1'b0);
      snap(1'b0);
      rd(3'd0); rd(3'd2); rd(3'd6);

      length_error = 1'b1; tick(); length_error = 1'b0;
      idle(4);
      bad();
      snap(1'b0);
      rd(3'd4); rd(3'd1);
      bad();
      snap(1'b0);
      rd(3'd4);

      local_invalid = 1'b1; tick();
      crc_check_invalid = 1'b1; bad_frame_get = 1'b1; tick();
      crc_check_invalid = 1'b0; bad_frame_get = 1'b0; local_invalid = 1'b0;
      bad();
      snap(1'b0);
      rd(3'd3); rd(3'd5);

      good_frame_get = 1'b1; bad_frame_get = 1'b1; frame_len = 16'd100; tick();
      good_frame_get = 1'b0; bad_frame_get = 1'b0;
      good(16'd60, 1'b0, 1'b1);
      snap(1'b0);
      rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd7);

      for (int i = 0; i < 8; i++) good(16'd9000, 1'b0, 1'b0);
      snap(1'b0);
      rd(3'd2);
      good(16'd9000, 1'b0, 1'b0);
      snap(1'b0);
      rd(3'd2);

      snap(1'b1);
      for (int i = 0; i < 5; i++) good(16'd100, 1'b0, 1'b0);
      good_frame_get = 1'b1; frame_len = 16'd100; stat_snap = 1'b1; clr_on_snap = 1'b1; tick();
      good_frame_get = 1'b0; stat_snap = 1'b0; clr_on_snap = 1'b0;
      rd(3'd0);
      snap(1'b0);
      rd(3'd0); rd(3'd2);

      good(16'd64, 1'b0, 1'b0);
      stat_rd = 1'b1; stat_addr = 3'd0; stat_snap = 1'b1; tick();
      stat_snap = 1'b0;
      for (int a = 0; a < 8; a++) begin
         stat_addr = 3'(a);
         tick();
      end
      stat_rd = 1'b0;
      idle(2);

      local_invalid = 1'b1; stat_rd = 1'b1; stat_addr = 3'd0; tick();
      local_invalid = 1'b0; stat_rd = 1'b0;
      reset = 1'b1;
      #1;
      check("arst_valid", 64'(stat_valid), 64'd0);
      check("arst_data", stat_data, 64'd0);
      check("arst_valid_s", 64'(stat_valid_s), 64'd0);
      check("arst_data_s", stat_data_s, 64'd0);
      sb.delete();
      exp_valid = 1'b0;
      model_zero();
      idle(2);
      reset = 1'b0;
      idle(1);
      bad();
      snap(1'b0);
      rd(3'd5); rd(3'd1); rd(3'd0);
      idle(3);
      check("sb_drain", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
